ram_1port_scan_init: RTL
========================

// Module: ram_1port_scan_init
// PURPOSE
//  Requester-side engine for the single-port RAM valid/retry protocol (req_* out, ack_* in).
//  On start, writes a seeded pattern to every address, then reads each address back and checks it.
//  Reports pass/fail, error count and first failing address.
//  Used as the built-in self-test and initialiser in front of ram_1port_fast instances.
// PARAMETERS
//  Width   16   data width; must match the RAM
//  Size    256  number of words; must be a power of 2
//  AddrW   8    address width, `log2(Size) from logfunc.h
//  MaxOut  4    maximum number of read requests awaiting ack (1..15)
// PORTS
//  clk             input   1        clock; all logic on rising edge
//  reset           input   1        asynchronous reset, active-low (asserted when 0)
//  start           input   1        one-cycle pulse; honoured only in IDLE or DONE
//  seed            input   Width    pattern seed; sampled when start is accepted
//  busy            output  1        high in WRITE, READ and DRAIN
//  done            output  1        high in DONE until the next accepted start
//  pass            output  1        valid while done; 1 when err_count==0 and proto_err==0
//  err_count       output  AddrW+1  number of read-back mismatches; saturates at Size
//  first_err_addr  output  AddrW    address of the first mismatch; 0 if none
//  proto_err       output  1        sticky; set by an ack arriving with no read outstanding
//  req_valid       output  1        request valid
//  req_retry       input   1        RAM stall; transfer when req_valid && !req_retry
//  req_we          output  1        1=write, 0=read
//  req_addr        output  AddrW    word address
//  req_data        output  Width    write data; 0 on reads
//  ack_valid       input   1        read data valid
//  ack_retry       output  1        always 0 (engine never stalls acks)
//  ack_data        input   Width    read data
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (busy, done, pass, err_count, first_err_addr, proto_err,
//    req_*, ack_retry). Reset mid-run aborts at once; req_valid drops asynchronously.
//  - pattern(a) = seed_q ^ {{(Width-AddrW){1'b0}}, a}. seed_q is latched on the accepted start.
//  - Handshake: once req_valid is high, req_we, req_addr and req_data hold until accepted.
//    req_valid never drops without acceptance, except on reset.
//  - IDLE/DONE --start--> WRITE: wr_addr=0, rd_addr=0, ck_addr=0, outstanding=0.
//    Also clears err_count, first_err_addr, proto_err and done.
//  - WRITE: issue write(wr_addr, pattern(wr_addr)); wr_addr++ on each transfer.
//    Writes return no ack. Transfer at addr Size-1 -> READ on the next cycle.
//  - READ: issue read(rd_addr) only while outstanding<MaxOut.
//    An ack in the same cycle frees a slot, so req_valid may stay high.
//    rd_addr++ on each transfer. Transfer at Size-1 -> DRAIN.
//  - outstanding: +1 on read transfer; -1 on ack_valid; both in the same cycle = unchanged.
//  - Check (any state): on ack_valid with outstanding>0, compare ack_data to pattern(ck_addr).
//    On mismatch: err_count++ (saturating at Size); if err_count was 0, first_err_addr=ck_addr.
//    ck_addr++ on every ack. Acks return in request order.
//  - ack_valid with outstanding==0: set proto_err; no other state changes.
//  - DRAIN: req_valid=0. When outstanding==0 and ck_addr has wrapped (Size acks seen) -> DONE.
//  - DONE: done=1; pass is combinational from err_count and proto_err. start while busy is ignored.
//  - Counters are AddrW+1 bits wide so that terminal count Size is distinguishable from 0.
// STRUCTURE
//  - Shared header ram_scan_defs.h: state localparams S_IDLE=0, S_WRITE=1, S_READ=2,
//    S_DRAIN=3, S_DONE=4 (3-bit); pattern function macro.
//  - One sub-module, ram_scan_checker: holds ck_addr, the compare, err_count,
//    first_err_addr and proto_err.
//  - Top holds the FSM, the wr/rd address counters and the outstanding counter.
// TESTING
//  1. Ideal RAM (retry=0, 1-cycle ack), seed=16'hA5A5 -> 256 writes, 256 reads;
//     done with pass=1, err_count=0; 514 cycles or fewer from start.
//  2. RAM corrupts addr 8'h37 and 8'h80 (bit 0 flipped) -> err_count=2,
//     first_err_addr=8'h37, pass=0.
//  3. Random req_retry at 50% -> fields stable while stalled; no lost or duplicate address;
//     pass=1.
//  4. Ack latency 10 cycles, MaxOut=4 -> outstanding never exceeds 4;
//     req_valid low whenever 4 reads are pending.
//  5. Spurious ack_valid pulse in IDLE -> proto_err=1.
//     Next start clears proto_err; that run ends with pass=1.
//  6. reset=0 asserted in READ at rd_addr=100 -> all outputs 0 immediately.
//     Restart completes with pass=1; start pulsed while busy is ignored.

Source files
------------

// File: rtl/ram_1port_scan_init_pkg.sv
// Shared definitions for the RAM scan/initialise engine: FSM encoding,
// outstanding-read counter width and the counter update helper.
package ram_1port_scan_init_pkg;

  // Engine states; encoding is fixed so the state can be probed by debug logic.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Outstanding-read counter is sized for the largest legal MaxOut (15).
  localparam int OUT_W = 4;

  // Read-slot accounting: a transfer and an ack in the same cycle cancel.
  function automatic logic [OUT_W-1:0] out_update(
    input logic [OUT_W-1:0] cur,
    input logic             inc,
    input logic             dec
  );
    logic [OUT_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec) nxt = cur + 1'b1;
    if (dec && !inc) nxt = cur - 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/ram_1port_scan_init_checker.sv
// Read-back checker: walks the expected address in ack order, compares each
// ack against the seeded pattern and keeps the error summary.
module ram_1port_scan_init_checker
  import ram_1port_scan_init_pkg::*;
#(
  parameter int Width = 16,
  parameter int Size  = 256,
  parameter int AddrW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             pending,
  input  logic [Width-1:0] seed_q,
  input  logic             ack_valid,
  input  logic [Width-1:0] ack_data,
  output logic             ck_wrapped,
  output logic [AddrW:0]   err_count,
  output logic [AddrW-1:0] first_err_addr,
  output logic             proto_err
);

  localparam logic [AddrW:0] TERM = (AddrW+1)'(Size);

  logic [AddrW:0]   ck_addr;
  logic [Width-1:0] expect_data;
  logic             hit;
  logic             miss;

  // An ack only counts when a read is actually waiting for it.
  assign hit         = ack_valid && pending;
  assign expect_data = seed_q ^ Width'(ck_addr[AddrW-1:0]);
  assign miss        = hit && (ack_data != expect_data);
  assign ck_wrapped  = (ck_addr == TERM);

  // Check-address walk, saturating error count, first-failure capture, sticky protocol flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ck_addr        <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      proto_err      <= 1'b0;
    end else if (clr) begin
      ck_addr        <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      proto_err      <= 1'b0;
    end else begin
      if (hit) ck_addr <= ck_addr + 1'b1;
      if (miss) begin
        if (err_count != TERM) err_count <= err_count + 1'b1;
        if (err_count == '0)   first_err_addr <= ck_addr[AddrW-1:0];
      end
      if (ack_valid && !pending) proto_err <= 1'b1;
    end
  end

endmodule

// File: rtl/ram_1port_scan_init.sv
// Built-in self-test / initialiser for a single-port RAM on the valid/retry
// protocol: writes pattern(a) to every word, reads every word back with a
// bounded number of reads in flight, and reports the result.
module ram_1port_scan_init
  import ram_1port_scan_init_pkg::*;
#(
  parameter int Width  = 16,
  parameter int Size   = 256,
  parameter int AddrW  = 8,
  parameter int MaxOut = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [Width-1:0] seed,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AddrW:0]   err_count,
  output logic [AddrW-1:0] first_err_addr,
  output logic             proto_err,
  output logic             req_valid,
  input  logic             req_retry,
  output logic             req_we,
  output logic [AddrW-1:0] req_addr,
  output logic [Width-1:0] req_data,
  input  logic             ack_valid,
  output logic             ack_retry,
  input  logic [Width-1:0] ack_data
);

  localparam logic [AddrW:0]   LAST    = (AddrW+1)'(Size - 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MaxOut);

  state_t           state;
  logic [AddrW:0]   wr_addr;
  logic [AddrW:0]   rd_addr;
  logic [AddrW:0]   wr_inc;
  logic [AddrW:0]   rd_nxt;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] out_nxt;
  logic [Width-1:0] seed_q;
  logic             xfer;
  logic             rd_xfer;
  logic             ack_hit;
  logic             go;
  logic             pending;
  logic             ck_wrapped;

  assign xfer      = req_valid && !req_retry;
  assign rd_xfer   = xfer && !req_we;
  assign pending   = (outstanding != '0);
  assign ack_hit   = ack_valid && pending;
  assign go        = start && ((state == S_IDLE) || (state == S_DONE));
  assign out_nxt   = out_update(outstanding, rd_xfer, ack_hit);
  assign wr_inc    = wr_addr + 1'b1;
  assign rd_nxt    = rd_addr + {{AddrW{1'b0}}, rd_xfer};
  assign ack_retry = 1'b0;
  assign pass      = done && (err_count == '0) && !proto_err;

  // Main sequencer: request register, address counters and read-slot accounting.
  // The request fields only change when the register is empty or the current
  // request transfers, so a stalled request is held stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wr_addr     <= '0;
      rd_addr     <= '0;
      outstanding <= '0;
      seed_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      req_valid   <= 1'b0;
      req_we      <= 1'b0;
      req_addr    <= '0;
      req_data    <= '0;
    end else begin
      outstanding <= out_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_WRITE;
            wr_addr     <= '0;
            rd_addr     <= '0;
            outstanding <= '0;
            seed_q      <= seed;
            busy        <= 1'b1;
            done        <= 1'b0;
            // pattern(0) is the seed itself
            req_valid   <= 1'b1;
            req_we      <= 1'b1;
            req_addr    <= '0;
            req_data    <= seed;
          end
        end
        S_WRITE: begin
          if (xfer) begin
            if (wr_addr == LAST) begin
              // first read goes out straight away; no reads are in flight yet
              state     <= S_READ;
              req_valid <= 1'b1;
              req_we    <= 1'b0;
              req_addr  <= '0;
              req_data  <= '0;
            end else begin
              wr_addr  <= wr_inc;
              req_addr <= wr_inc[AddrW-1:0];
              req_data <= seed_q ^ Width'(wr_inc[AddrW-1:0]);
            end
          end
        end
        S_READ: begin
          if (!(req_valid && req_retry)) begin
            if (rd_xfer && (rd_addr == LAST)) begin
              state     <= S_DRAIN;
              req_valid <= 1'b0;
            end else begin
              // a same-cycle ack is already folded into out_nxt
              rd_addr   <= rd_nxt;
              req_addr  <= rd_nxt[AddrW-1:0];
              req_valid <= (out_nxt < MAX_OUT);
            end
          end
        end
        S_DRAIN: begin
          if (!pending && ck_wrapped) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  ram_1port_scan_init_checker #(
    .Width (Width),
    .Size  (Size),
    .AddrW (AddrW)
  ) u_checker (
    .clk            (clk),
    .reset          (reset),
    .clr            (go),
    .pending        (pending),
    .seed_q         (seed_q),
    .ack_valid      (ack_valid),
    .ack_data       (ack_data),
    .ck_wrapped     (ck_wrapped),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .proto_err      (proto_err)
  );

endmodule
